// File: rtl/ll_chan_sched.sv
// Round-robin line-length scheduler: one shared abs-difference/accumulate datapath for NUM_CH channels.
// Optional macro LL_NORM_EN reports the window mean absolute difference instead of the raw window sum.
module ll_chan_sched #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIN_LEN    = 256
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic [NUM_CH-1:0]                           ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                ch_din,
    output logic [NUM_CH-1:0]                           ch_ready,
    output logic [DATA_WIDTH+$clog2(WIN_LEN):0]         ll_dout,
    output logic [$clog2(NUM_CH)-1:0]                   ll_ch,
    output logic                                        ll_valid
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(WIN_LEN);
    localparam int unsigned DIF_W = DATA_WIDTH + 1;
    localparam int unsigned ACC_W = DATA_WIDTH + 1 + CNT_W;

    logic [DATA_WIDTH-1:0] din_arr [NUM_CH];

    // Round-robin pointer and grant
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W:0]   cand;
    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;

    // Stage 1: accepted sample with the previous sample of its channel
    logic                  s1_vld_q, s1_prime_q;
    logic [CH_W-1:0]       s1_ch_q;
    logic [DATA_WIDTH-1:0] s1_din_q, s1_prev_q;

    // Stage 2: absolute difference awaiting accumulation
    logic             s2_vld_q;
    logic [CH_W-1:0]  s2_ch_q;
    logic [DIF_W-1:0] s2_abs_q;

    // Per-channel context
    logic [DATA_WIDTH-1:0] prev_q [NUM_CH];
    logic [NUM_CH-1:0]     primed_q;
    logic [ACC_W-1:0]      acc_q  [NUM_CH];
    logic [CNT_W-1:0]      cnt_q  [NUM_CH];

    logic [DIF_W-1:0] diff_c, abs_c;
    logic [ACC_W-1:0] sum_c, dout_d;
    logic             last_c;

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            din_arr[i] = ch_din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid channel at or above the pointer, with wrap
    always_comb begin
        ch_ready  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        ptr_d     = ptr_q;
        if (rst && en) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cand = (CH_W+1)'(ptr_q) + (CH_W+1)'(k);
                if (cand >= (CH_W+1)'(NUM_CH)) begin
                    cand = cand - (CH_W+1)'(NUM_CH);
                end
                if (!gnt_found && ch_valid[cand[CH_W-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand[CH_W-1:0];
                end
            end
        end
        if (gnt_found) begin
            ch_ready[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    // Exact difference in DATA_WIDTH+1 bits, then magnitude
    always_comb begin
        diff_c = {s1_din_q[DATA_WIDTH-1], s1_din_q} - {s1_prev_q[DATA_WIDTH-1], s1_prev_q};
        abs_c  = diff_c[DIF_W-1] ? (~diff_c) + DIF_W'(1) : diff_c;
    end

    always_comb begin
        sum_c  = acc_q[s2_ch_q] + ACC_W'(s2_abs_q);
        last_c = (cnt_q[s2_ch_q] == CNT_W'(WIN_LEN - 1));
`ifdef LL_NORM_EN
        dout_d = sum_c >> CNT_W;
`else
        dout_d = sum_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_prime_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_din_q   <= '0;
            s1_prev_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_ch_q    <= '0;
            s2_abs_q   <= '0;
            primed_q   <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                prev_q[i] <= '0;
                acc_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
            ll_dout  <= '0;
            ll_ch    <= '0;
            ll_valid <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= gnt_found;
            if (gnt_found) begin
                s1_ch_q           <= gnt_idx;
                s1_din_q          <= din_arr[gnt_idx];
                s1_prev_q         <= prev_q[gnt_idx];
                s1_prime_q        <= !primed_q[gnt_idx];
                prev_q[gnt_idx]   <= din_arr[gnt_idx];
                primed_q[gnt_idx] <= 1'b1;
            end

            s2_vld_q <= s1_vld_q && !s1_prime_q;
            if (s1_vld_q) begin
                s2_ch_q  <= s1_ch_q;
                s2_abs_q <= abs_c;
            end

            // Only this stage touches acc/count, so same-channel back-to-back is safe
            ll_valid <= 1'b0;
            if (s2_vld_q) begin
                if (last_c) begin
                    ll_dout         <= dout_d;
                    ll_ch           <= s2_ch_q;
                    ll_valid        <= 1'b1;
                    acc_q[s2_ch_q]  <= '0;
                    cnt_q[s2_ch_q]  <= '0;
                end else begin
                    acc_q[s2_ch_q]  <= sum_c;
                    cnt_q[s2_ch_q]  <= cnt_q[s2_ch_q] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ll_chan_sched.sv
// Bench for ll_chan_sched (2 channels, window of 4): vector table, directed corner sequences
// and randomized traffic checked against a per-sample window model.
module tb_ll_chan_sched;

    localparam int unsigned NCH   = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned WL    = 4;
    localparam int unsigned ACC_W = 35;
`ifdef LL_NORM_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0]    ch_ready;
    logic [ACC_W-1:0]  ll_dout;
    logic              ll_ch;
    logic              ll_valid;

    always #5 clk = ~clk;

    ll_chan_sched #(.NUM_CH(NCH), .DATA_WIDTH(DW), .WIN_LEN(WL)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ch_valid (ch_valid),
        .ch_din   (ch_din),
        .ch_ready (ch_ready),
        .ll_dout  (ll_dout),
        .ll_ch    (ll_ch),
        .ll_valid (ll_valid)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: per-channel window state, updated at the accept edge
    typedef struct {
        int     due;
        int     ch;
        longint val;
    } pend_t;

    longint           mprev  [NCH];
    bit               mprimed[NCH];
    longint           msum   [NCH];
    int               mn     [NCH];
    int               mptr;
    pend_t            pq[$];
    logic             exp_v;
    logic [ACC_W-1:0] exp_d;
    logic             exp_c;

    int               pulses [NCH];
    logic [ACC_W-1:0] last_dout;

    typedef struct {
        logic             en;
        logic [1:0]       v;
        logic [31:0]      d0;
        logic [1:0]       rdy;
        logic             llv;
        logic [ACC_W-1:0] dout;
        logic             ch;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic r, input logic e, input logic [1:0] v);
        if (!r || !e) return -1;
        for (int k = 0; k < int'(NCH); k++) begin
            int i;
            i = (mptr + k) % int'(NCH);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input int g, input logic [31:0] raw);
        longint x, dif;
        cyc++;
        if (!r) begin
            for (int c = 0; c < int'(NCH); c++) begin
                mprev[c] = 0; mprimed[c] = 0; msum[c] = 0; mn[c] = 0;
            end
            mptr = 0;
            pq.delete();
            exp_v = 1'b0; exp_d = '0; exp_c = 1'b0;
            return;
        end
        exp_v = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            exp_v = 1'b1;
            exp_d = ACC_W'(pq[0].val >>> SH);
            exp_c = 1'(pq[0].ch);
            void'(pq.pop_front());
        end
        if (g >= 0) begin
            mptr = (g + 1) % int'(NCH);
            x = longint'($signed(raw));
            if (!mprimed[g]) begin
                mprimed[g] = 1'b1;
            end else begin
                dif = x - mprev[g];
                if (dif < 0) dif = -dif;
                msum[g] += dif;
                mn[g]++;
                if (mn[g] == int'(WL)) begin
                    pq.push_back('{cyc + 2, g, msum[g]});
                    msum[g] = 0;
                    mn[g]   = 0;
                end
            end
            mprev[g] = x;
        end
    endtask

    // One clock: drive at negedge, check grant before the edge, outputs just after it
    task automatic step(input logic r, input logic e, input logic [1:0] v,
                        input logic [31:0] d0, input logic [31:0] d1, output logic [1:0] rdy_seen);
        int g;
        logic [1:0] er;
        @(negedge clk);
        rst = r; en = e; ch_valid = v; ch_din = {d1, d0};
        #1;
        g  = model_grant(r, e, v);
        er = (g < 0) ? 2'b00 : 2'(2'b01 << g);
        rdy_seen = ch_ready;
        chk("ch_ready", 64'(ch_ready), 64'(er));
        @(posedge clk);
        model_edge(r, g, (g == 1) ? d1 : d0);
        #1;
        chk("ll_valid", 64'(ll_valid), 64'(exp_v));
        chk("ll_dout", 64'(ll_dout), 64'(exp_d));
        chk("ll_ch", 64'(ll_ch), 64'(exp_c));
        if (ll_valid === 1'b1) begin
            pulses[ll_ch]++;
            last_dout = ll_dout;
        end
    endtask

    task automatic clr_pulses();
        pulses[0] = 0;
        pulses[1] = 0;
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return $urandom();
            2:       return 32'h7FFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    logic [1:0]  rs;
    logic [31:0] samp[$];

    initial begin
        rst = 1'b0; en = 1'b0; ch_valid = '0; ch_din = '0;
        last_dout = '0;
        clr_pulses();

        tbl[0] = '{1'b1, 2'b01, 32'd0,         2'b01, 1'b0, '0, 1'b0};
        tbl[1] = '{1'b1, 2'b01, 32'd1,         2'b01, 1'b0, '0, 1'b0};
        tbl[2] = '{1'b1, 2'b01, 32'd10,        2'b01, 1'b0, '0, 1'b0};
        tbl[3] = '{1'b1, 2'b01, 32'd4,         2'b01, 1'b0, '0, 1'b0};
        tbl[4] = '{1'b1, 2'b01, 32'hFFFF_FFFA, 2'b01, 1'b0, '0, 1'b0};
        tbl[5] = '{1'b1, 2'b00, 32'd0,         2'b00, 1'b0, '0, 1'b0};
        tbl[6] = '{1'b1, 2'b00, 32'd0,         2'b00, 1'b1, ACC_W'(26 >> SH), 1'b0};
        tbl[7] = '{1'b1, 2'b00, 32'd0,         2'b00, 1'b0, ACC_W'(26 >> SH), 1'b0};

        // Reset with both channels requesting
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b11, 32'd5, 32'd6, rs);
            chk("reset_ready", 64'(rs), 64'd0);
            chk("reset_valid", 64'(ll_valid), 64'd0);
            chk("reset_dout", 64'(ll_dout), 64'd0);
            chk("reset_ch", 64'(ll_ch), 64'd0);
        end

        // Single-channel window from the vector table
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].en, tbl[i].v, tbl[i].d0, 32'd0, rs);
            chk($sformatf("tbl%0d_ready", i), 64'(rs), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(ll_valid), 64'(tbl[i].llv));
            chk($sformatf("tbl%0d_dout", i), 64'(ll_dout), 64'(tbl[i].dout));
            chk($sformatf("tbl%0d_ch", i), 64'(ll_ch), 64'(tbl[i].ch));
        end

        // Fairness with both channels always valid
        step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        clr_pulses();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 2'b11, rnd_data(), rnd_data(), rs);
            chk("rr_order", 64'(rs), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        chk("rr_pulses_ch0", 64'(pulses[0]), 64'd1);
        chk("rr_pulses_ch1", 64'(pulses[1]), 64'd1);

        // Extreme alternating samples
        step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        clr_pulses();
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 2'b01, (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000, 32'd0, rs);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        chk("ext_pulses", 64'(pulses[0]), 64'd1);
        chk("ext_dout", 64'(last_dout), 64'(35'h3_FFFF_FFFC >> SH));

        // Enable gap mid-window
        step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        clr_pulses();
        samp = '{32'd5, 32'd8, 32'd2};
        foreach (samp[i]) step(1'b1, 1'b1, 2'b01, samp[i], 32'd0, rs);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 2'b01, 32'd99, 32'd0, rs);
            chk("gap_ready", 64'(rs), 64'd0);
        end
        chk("gap_no_output", 64'(pulses[0]), 64'd0);
        step(1'b1, 1'b1, 2'b01, 32'd7, 32'd0, rs);
        step(1'b1, 1'b1, 2'b01, 32'd7, 32'd0, rs);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        chk("gap_pulses", 64'(pulses[0]), 64'd1);
        chk("gap_dout", 64'(last_dout), 64'(14 >> SH));

        // Reset mid-window re-primes the channel
        step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        clr_pulses();
        samp = '{32'd0, 32'd100, 32'd50};
        foreach (samp[i]) step(1'b1, 1'b1, 2'b01, samp[i], 32'd0, rs);
        step(1'b0, 1'b1, 2'b01, 32'd77, 32'd0, rs);
        samp = '{32'd1000, 32'd1001, 32'd1003, 32'd1000};
        foreach (samp[i]) step(1'b1, 1'b1, 2'b01, samp[i], 32'd0, rs);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        chk("rst_mid_no_output", 64'(pulses[0]), 64'd0);
        step(1'b1, 1'b1, 2'b01, 32'd1010, 32'd0, rs);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 32'd0, 32'd0, rs);
        chk("rst_mid_pulses", 64'(pulses[0]), 64'd1);
        chk("rst_mid_dout", 64'(last_dout), 64'(16 >> SH));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), rnd_data(), rnd_data(), rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
